// File: rtl/frame_tx_1101_pkg.sv
// Shared frame constants (also consumed by the receive-side 1101 detectors)
// and the transmitter's state type and counter-width helper.
`ifndef FRAME_TX_1101_DEFS
`define FRAME_TX_1101_DEFS
`define FT1101_PREAMBLE 4'b1101
`define FT1101_PRE_LEN  4
`define FT1101_STATE_W  3
`define FT1101_S_IDLE   3'b000
`define FT1101_S_PRE    3'b001
`define FT1101_S_DATA   3'b010
`define FT1101_S_PAR    3'b100
`endif

package frame_tx_1101_pkg;

    localparam int PRE_LEN = `FT1101_PRE_LEN;

    typedef enum logic [`FT1101_STATE_W-1:0] {
        S_IDLE = `FT1101_S_IDLE,
        S_PRE  = `FT1101_S_PRE,
        S_DATA = `FT1101_S_DATA,
        S_PAR  = `FT1101_S_PAR
    } state_t;

    // Counter must hold the largest reload value: PRE_LEN-1 or DATA_W-1.
    function automatic int cnt_width(input int data_w);
        int m;
        m = (data_w > PRE_LEN) ? data_w : PRE_LEN;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/frame_tx_1101_bit_counter.sv
// Loadable down-counter; tc flags the last cycle of the current state.
module frame_tx_1101_bit_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/frame_tx_1101.sv
// Serial frame transmitter: preamble, MSB-first payload, even parity bit.
// Moore FSM with registered sout/busy/done.
module frame_tx_1101
    import frame_tx_1101_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter logic [PRE_LEN-1:0] PREAMBLE = `FT1101_PREAMBLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(DATA_W);
    // The first preamble bit goes straight to sout on accept, so only the rest is shifted.
    localparam int SW = PRE_LEN - 1 + DATA_W;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   shreg;
    logic            par_q;
    logic            tc;
    logic            cnt_load;
    logic            cnt_en;
    logic [CW-1:0]   cnt_val;
    logic            sout_d;
    logic            busy_d;
    logic            done_d;

    frame_tx_1101_bit_counter #(.W(CW)) u_bit_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .tc       (tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PRE;
                    cnt_load  = 1'b1;
                    cnt_val   = CW'(PRE_LEN - 1);
                end
            end
            S_PRE: begin
                if (tc) begin
                    state_nxt = S_DATA;
                    cnt_load  = 1'b1;
                    cnt_val   = CW'(DATA_W - 1);
                end else begin
                    state_nxt = S_PRE;
                    cnt_en    = 1'b1;
                end
            end
            S_DATA: begin
                if (tc) begin
                    state_nxt = S_PAR;
                    cnt_load  = 1'b1;
                end else begin
                    state_nxt = S_DATA;
                    cnt_en    = 1'b1;
                end
            end
            S_PAR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Values the outputs take in the state being entered.
    always_comb begin
        sout_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sout_d = PREAMBLE[PRE_LEN-1];
                    busy_d = 1'b1;
                end
            end
            S_PRE: begin
                sout_d = shreg[SW-1];
                busy_d = 1'b1;
            end
            S_DATA: begin
                sout_d = tc ? par_q : shreg[SW-1];
                busy_d = 1'b1;
            end
            S_PAR:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sout <= sout_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
            par_q <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            shreg <= {PREAMBLE[PRE_LEN-2:0], data};
            par_q <= ^data;
        end else if ((state == S_PRE) || (state == S_DATA)) begin
            shreg <= {shreg[SW-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_frame_tx_1101.sv
// Bench for frame_tx_1101: per-cycle {sout,busy,done} scoreboard plus a
// looped-back Moore 1101 detector.
module tb_frame_tx_1101;

    localparam int W = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       sout;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    logic [2:0] det_state;
    logic       det;

    frame_tx_1101 #(.DATA_W(8), .PREAMBLE(4'b1101)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .data  (data),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    // Moore 1101 detector (overlapping) fed from sout.
    always @(posedge clock) begin
        if (reset) begin
            det_state <= 3'd0;
        end else begin
            case (det_state)
                3'd0:    det_state <= sout ? 3'd1 : 3'd0;
                3'd1:    det_state <= sout ? 3'd2 : 3'd0;
                3'd2:    det_state <= sout ? 3'd2 : 3'd3;
                3'd3:    det_state <= sout ? 3'd4 : 3'd0;
                3'd4:    det_state <= sout ? 3'd2 : 3'd0;
                default: det_state <= 3'd0;
            endcase
        end
    end
    assign det = (det_state == 3'd4);

    // Expected {sout,busy,done}: 13 busy frame cycles then the done cycle.
    task automatic push_frame(input logic [7:0] d);
        logic [12:0] bits;
        bits = {4'b1101, d, ^d};
        for (int b = 12; b >= 0; b--) exp_q.push_back({bits[b], 1'b1, 1'b0});
        exp_q.push_back(3'b001);
    endtask

    task automatic push_idle(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(3'b000);
    endtask

    task automatic test_reset;
        logic [W-1:0] exp;
        @(negedge clock);
        reset = 1'b1; start = 1'b1; data = 8'hFF;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL reset cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
        // start stays high across the reset release; the frame must begin at the first free edge
        reset = 1'b0; data = 8'hA5;
        push_frame(8'hA5);
        push_idle(1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL frame_a5 cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
    endtask

    task automatic test_single_frame(input logic [7:0] d, input string name, output logic par_seen);
        logic [W-1:0] exp;
        @(negedge clock);
        start = 1'b1; data = d;
        push_frame(d);
        push_idle(1);
        par_seen = 1'bx;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 1) data = 8'($urandom_range(0, 255));
            if (i == 12) par_seen = sout;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: sout/busy/done=%b expected %b", name, i + 1, {sout, busy, done}, exp);
            end
        end
    endtask

    task automatic test_parity;
        logic p;
        test_single_frame(8'h07, "frame_07", p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_07: got %b expected 1", p);
        end
        test_single_frame(8'h00, "frame_00", p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_00: got %b expected 0", p);
        end
        for (int r = 0; r < 3; r++) test_single_frame(8'($urandom_range(0, 255)), "frame_rand", p);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp;
        @(negedge clock);
        start = 1'b1; data = 8'h3C;
        for (int f = 0; f < 3; f++) push_frame(8'h3C);
        push_idle(1);
        for (int i = 0; i < 43; i++) begin
            @(negedge clock);
            if (i == 41) start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
    endtask

    task automatic test_mid_start;
        logic [W-1:0] exp;
        @(negedge clock);
        start = 1'b1; data = 8'h5A;
        push_frame(8'h5A);
        push_idle(2);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            if (i == 4) begin start = 1'b1; data = 8'hFF; end
            if (i == 13) start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL mid_start cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] exp;
        @(negedge clock);
        start = 1'b1; data = 8'h96;
        push_frame(8'h96);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        push_idle(3);
        push_frame(8'hC3);
        push_idle(1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            reset = 1'b0;
            start = (i == 2);
            if (i == 2) data = 8'hC3;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL reset_mid recovery cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
    endtask

    task automatic test_loopback;
        logic [W-1:0] exp;
        push_idle(2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL loopback idle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
        end
        start = 1'b1; data = 8'h00;
        push_frame(8'h00);
        push_idle(1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 3'bxxx;
            vectors++;
            if ({sout, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL loopback cycle %0d: sout/busy/done=%b expected %b", i + 1, {sout, busy, done}, exp);
            end
            if (i <= 4) begin
                vectors++;
                if (det !== (i == 4)) begin
                    miscompares++;
                    $display("FAIL loopback_det cycle %0d: det=%b expected %b", i + 1, det, (i == 4));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clock);
        test_reset;
        test_parity;
        test_back_to_back;
        test_mid_start;
        test_reset_mid;
        test_loopback;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
